snitch_sb_tag_table: RTL and testbench
======================================

SNITCH_SB_TAG_TABLE -- requirements
Module: snitch_sb_tag_table

Interface
REQ-001 SHALL have parameter NrTags, default 8, giving the number of one-hot tags and table entries (2..32).
REQ-002 SHALL have parameter RegAddrWidth, default 5, giving the width of a register address.
REQ-003 SHALL have port clk_i  input  1  clock; all state on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port issue_valid_i  input  1  instruction requests a tag.
REQ-006 SHALL have port issue_ready_o  output  1  tag granted this cycle if valid.
REQ-007 SHALL have port issue_rd_i  input  RegAddrWidth  destination register; 0 means no writeback.
REQ-008 SHALL have ports issue_rs1_i and issue_rs2_i  input  RegAddrWidth  source registers.
REQ-009 SHALL have port issue_tag_o  output  NrTags  one-hot tag granted; don't-care when issue_ready_o=0.
REQ-010 SHALL have port retire_valid_i  input  1  an in-flight instruction completes.
REQ-011 SHALL have port retire_tag_i  input  NrTags  one-hot tag being returned.
REQ-012 SHALL have port inflight_o  output  $clog2(NrTags)+1  number of allocated tags.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse on an illegal retire.

Function
REQ-014 SHALL hold one entry per tag: valid bit plus stored rd.
REQ-015 SHALL keep free tags in an internal FIFO, depth NrTags, width NrTags, storing one-hot tokens.
REQ-016 SHALL drive issue_tag_o combinationally from the free-FIFO head.
REQ-017 SHALL assert hazard when any valid entry's rd is nonzero and equals issue_rs1_i, issue_rs2_i or issue_rd_i; register 0 never hazards.
REQ-018 SHALL drive issue_ready_o = free FIFO not empty AND NOT hazard, with no dependence on issue_valid_i.
REQ-019 SHALL, on issue_valid_i AND issue_ready_o, pop the FIFO and set the tagged entry valid with rd in the next cycle.
REQ-020 SHALL accept a retire only when retire_valid_i=1, retire_tag_i is exactly one-hot, and that entry is valid.
REQ-021 SHALL, on an accepted retire, clear the entry valid bit and push retire_tag_i to the FIFO tail in the next cycle.
REQ-022 SHALL ignore a retire with zero, multi-hot, or not-valid tag, and pulse err_o high in the next cycle.
REQ-023 SHALL compute hazard and ready from registered state only; a tag retiring in cycle N still blocks issue in cycle N.
REQ-024 SHALL, on simultaneous accepted issue and retire, perform both; inflight_o is unchanged.
REQ-025 SHALL, when the FIFO is empty and a retire arrives, deassert issue_ready_o in that cycle; the returned tag is grantable from the next cycle.
REQ-026 SHALL wrap FIFO pointers modulo NrTags, including non-power-of-two NrTags.
REQ-027 SHALL make FIFO overflow impossible by construction, since only valid-entry tags are pushed.
REQ-028 SHALL keep inflight_o equal to the number of valid entries, within 0..NrTags.

Reset
REQ-029 SHALL, on rst_ni low, immediately clear all entry valid bits, rd fields, inflight_o and err_o.
REQ-030 SHALL reset the FIFO full, with slot i holding 1<<i, read pointer 0, write pointer 0 and count NrTags.
REQ-031 SHALL discard all in-flight state on reset mid-operation; the first grant after reset is always tag 0x01.

Structure
REQ-032 SHALL place tag_t (logic [NrTags-1:0]), the entry struct {valid, rd} and a one-hot check function in the shared snitch_sb_pkg.
REQ-033 SHALL implement the free-tag FIFO as one sub-module, snitch_sb_tag_fifo, with parameterised reset contents; the table, hazard logic and error detection live in the top module.

Verification
REQ-034 SHALL cover post-reset order: 8 back-to-back issues with rd=1..8, no retires -> tags 0x01,0x02,...,0x80, then issue_ready_o=0 and inflight_o=8.
REQ-035 SHALL cover RAW hazard: issue rd=5, then issue rs1=5 -> ready=0 until tag 0x01 is retired; ready=1 the cycle after retire.
REQ-036 SHALL cover x0 exemption: issue rd=0, then issue rs1=0 and rd=0 -> no stall; second grant is 0x02.
REQ-037 SHALL cover FIFO recycling: fill all 8, retire 0x04 then 0x10 -> next grants 0x04 then 0x10 in that order.
REQ-038 SHALL cover illegal retires: retire 0x03, retire 0x00, retire an unallocated tag -> err_o pulses once each and inflight_o is unchanged.
REQ-039 SHALL cover simultaneous events and mid-operation reset: same-cycle issue plus retire with inflight_o=3 -> stays 3; assert rst_ni with 5 in flight -> inflight_o=0 and the next grant is 0x01.

Source files
------------

// File: rtl/snitch_sb_pkg.sv
// Shared types and helpers for the scoreboard tag table and its free-tag FIFO.
// Types are sized for the default configuration; parameterised logic uses explicit widths.
package snitch_sb_pkg;

   localparam int unsigned DefNrTags       = 8;
   localparam int unsigned DefRegAddrWidth = 5;
   localparam int unsigned MaxNrTags       = 32;

   typedef logic [DefNrTags-1:0] tag_t;

   typedef struct packed {
      logic                       valid;
      logic [DefRegAddrWidth-1:0] rd;
   } entry_t;

   // True when exactly one bit is set; callers zero-extend narrower tags.
   function automatic logic is_onehot(input logic [MaxNrTags-1:0] v);
      return (v != '0) && ((v & (v - MaxNrTags'(1))) == '0);
   endfunction

endpackage

// File: rtl/snitch_sb_tag_fifo.sv
// Circular FIFO of free one-hot tags with parameterised reset contents.
// Head is presented combinationally; pointers wrap modulo Depth for any Depth.
module snitch_sb_tag_fifo #(
   parameter int unsigned             Depth      = 8,
   parameter int unsigned             Width      = 8,
   parameter logic [Depth*Width-1:0]  ResetData  = '0,
   parameter int unsigned             ResetCount = Depth
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  rptr_q, wptr_q;
   logic [CntW-1:0]  count_q;

   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign data_o  = mem_q[rptr_q];
   assign empty_o = (count_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= ResetData[i*Width +: Width];
         end
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= CntW'(ResetCount);
      end else begin
         if (push_i) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wrap_inc(wptr_q);
         end
         if (pop_i) begin
            rptr_q <= wrap_inc(rptr_q);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/snitch_sb_tag_table.sv
// Scoreboard tag table: grants one-hot tags to issuing instructions, tracks their rd,
// stalls on register hazards against in-flight entries and recycles tags on retire.
module snitch_sb_tag_table
   import snitch_sb_pkg::*;
#(
   parameter int unsigned NrTags       = DefNrTags,
   parameter int unsigned RegAddrWidth = DefRegAddrWidth
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   // Issue handshake: a tag transfers on a cycle where issue_valid_i && issue_ready_o;
   // issue_ready_o never looks at issue_valid_i, and issue_tag_o is only meaningful when ready.
   input  logic                      issue_valid_i,
   output logic                      issue_ready_o,
   input  logic [RegAddrWidth-1:0]   issue_rd_i,
   input  logic [RegAddrWidth-1:0]   issue_rs1_i,
   input  logic [RegAddrWidth-1:0]   issue_rs2_i,
   output logic [NrTags-1:0]         issue_tag_o,
   input  logic                      retire_valid_i,
   input  logic [NrTags-1:0]         retire_tag_i,
   output logic [$clog2(NrTags):0]   inflight_o,
   output logic                      err_o
);

   localparam int unsigned InfW = $clog2(NrTags) + 1;

   function automatic logic [NrTags*NrTags-1:0] onehot_tokens();
      logic [NrTags*NrTags-1:0] d;
      d = '0;
      for (int i = 0; i < NrTags; i++) begin
         d[i*NrTags + i] = 1'b1;
      end
      return d;
   endfunction

   localparam logic [NrTags*NrTags-1:0] FifoInit = onehot_tokens();

   logic [NrTags-1:0]       valid_q;
   logic [RegAddrWidth-1:0] rd_q [NrTags];
   logic [InfW-1:0]         inflight_q;
   logic                    err_q;

   logic [NrTags-1:0] fifo_head;
   logic              fifo_empty;
   logic              hazard;
   logic              issue_fire;
   logic              retire_ok;

   snitch_sb_tag_fifo #(
      .Depth      (NrTags),
      .Width      (NrTags),
      .ResetData  (FifoInit),
      .ResetCount (NrTags)
   ) i_free_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (retire_ok),
      .data_i  (retire_tag_i),
      .pop_i   (issue_fire),
      .data_o  (fifo_head),
      .empty_o (fifo_empty)
   );

   // Only registered entries are consulted, so a same-cycle retire still blocks issue.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NrTags; i++) begin
         if (valid_q[i] && (rd_q[i] != '0) &&
             ((rd_q[i] == issue_rs1_i) || (rd_q[i] == issue_rs2_i) ||
              (rd_q[i] == issue_rd_i))) begin
            hazard = 1'b1;
         end
      end
   end

   assign issue_ready_o = !fifo_empty && !hazard;
   assign issue_tag_o   = fifo_head;
   assign issue_fire    = issue_valid_i && issue_ready_o;
   assign retire_ok     = retire_valid_i && is_onehot(MaxNrTags'(retire_tag_i)) &&
                          ((retire_tag_i & valid_q) != '0);

   // A free tag's entry is never valid, so the issue and retire targets cannot collide.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < NrTags; i++) begin
            rd_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NrTags; i++) begin
            if (issue_fire && fifo_head[i]) begin
               valid_q[i] <= 1'b1;
               rd_q[i]    <= issue_rd_i;
            end else if (retire_ok && retire_tag_i[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case ({issue_fire, retire_ok})
            2'b10:   inflight_q <= inflight_q + InfW'(1);
            2'b01:   inflight_q <= inflight_q - InfW'(1);
            default: inflight_q <= inflight_q;
         endcase
         err_q <= retire_valid_i && !retire_ok;
      end
   end

   assign inflight_o = inflight_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_snitch_sb_tag_table.sv
// Directed bench for the scoreboard tag table: grant order, hazards, recycling,
// illegal retires, simultaneous issue/retire and reset mid-operation.
module tb_snitch_sb_tag_table;

   localparam int unsigned NrTags       = 8;
   localparam int unsigned RegAddrWidth = 5;

   logic                    clk_i;
   logic                    rst_ni;
   logic                    issue_valid_i;
   logic                    issue_ready_o;
   logic [RegAddrWidth-1:0] issue_rd_i;
   logic [RegAddrWidth-1:0] issue_rs1_i;
   logic [RegAddrWidth-1:0] issue_rs2_i;
   logic [NrTags-1:0]       issue_tag_o;
   logic                    retire_valid_i;
   logic [NrTags-1:0]       retire_tag_i;
   logic [3:0]              inflight_o;
   logic                    err_o;

   int checks = 0;
   int errors = 0;

   snitch_sb_tag_table #(
      .NrTags       (NrTags),
      .RegAddrWidth (RegAddrWidth)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .issue_valid_i  (issue_valid_i),
      .issue_ready_o  (issue_ready_o),
      .issue_rd_i     (issue_rd_i),
      .issue_rs1_i    (issue_rs1_i),
      .issue_rs2_i    (issue_rs2_i),
      .issue_tag_o    (issue_tag_o),
      .retire_valid_i (retire_valid_i),
      .retire_tag_i   (retire_tag_i),
      .inflight_o     (inflight_o),
      .err_o          (err_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // driver tasks: inputs change 1 time unit after a rising edge, checks follow a settle delay
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      issue_valid_i  = 1'b0;
      issue_rd_i     = '0;
      issue_rs1_i    = '0;
      issue_rs2_i    = '0;
      retire_valid_i = 1'b0;
      retire_tag_i   = '0;
      #1;
   endtask

   task automatic drive_issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      issue_valid_i = 1'b1;
      issue_rd_i    = rd;
      issue_rs1_i   = rs1;
      issue_rs2_i   = rs2;
      #1;
   endtask

   task automatic drive_retire(input logic [7:0] tag);
      retire_valid_i = 1'b1;
      retire_tag_i   = tag;
      #1;
   endtask

   task automatic apply_reset();
      idle();
      rst_ni = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (inflight_o !== 4'd0) begin
         errors++; $display("FAIL reset_inflight got %0d want 0", inflight_o);
      end
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL reset_err got %b want 0", err_o);
      end
      checks++;
      if (issue_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", issue_ready_o);
      end
      checks++;
      if (issue_tag_o !== 8'h01) begin
         errors++; $display("FAIL reset_tag got %h want 01", issue_tag_o);
      end
   endtask

   task automatic test_fill_order();
      logic [7:0] exp_tag;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         exp_tag = 8'h01 << i;
         drive_issue(5'(i + 1), 5'd0, 5'd0);
         checks++;
         if (issue_ready_o !== 1'b1 || issue_tag_o !== exp_tag) begin
            errors++;
            $display("FAIL fill_grant%0d got ready=%b tag=%h want ready=1 tag=%h",
                     i, issue_ready_o, issue_tag_o, exp_tag);
         end
         step();
      end
      idle();
      checks++;
      if (issue_ready_o !== 1'b0) begin
         errors++; $display("FAIL fill_ready_full got %b want 0", issue_ready_o);
      end
      checks++;
      if (inflight_o !== 4'd8) begin
         errors++; $display("FAIL fill_inflight got %0d want 8", inflight_o);
      end
   endtask

   task automatic test_raw_hazard();
      apply_reset();
      drive_issue(5'd5, 5'd0, 5'd0);
      step();
      idle();
      drive_issue(5'd6, 5'd5, 5'd0);
      checks++;
      if (issue_ready_o !== 1'b0) begin
         errors++; $display("FAIL raw_stall0 got %b want 0", issue_ready_o);
      end
      step();
      checks++;
      if (issue_ready_o !== 1'b0) begin
         errors++; $display("FAIL raw_stall1 got %b want 0", issue_ready_o);
      end
      drive_retire(8'h01);
      checks++;
      if (issue_ready_o !== 1'b0) begin
         errors++; $display("FAIL raw_retire_cycle got %b want 0", issue_ready_o);
      end
      step();
      retire_valid_i = 1'b0;
      retire_tag_i   = '0;
      #1;
      checks++;
      if (issue_ready_o !== 1'b1 || issue_tag_o !== 8'h02) begin
         errors++;
         $display("FAIL raw_release got ready=%b tag=%h want ready=1 tag=02", issue_ready_o, issue_tag_o);
      end
      step();
      idle();
      checks++;
      if (inflight_o !== 4'd1) begin
         errors++; $display("FAIL raw_inflight got %0d want 1", inflight_o);
      end
   endtask

   task automatic test_x0();
      apply_reset();
      drive_issue(5'd0, 5'd0, 5'd0);
      step();
      drive_issue(5'd0, 5'd0, 5'd0);
      checks++;
      if (issue_ready_o !== 1'b1 || issue_tag_o !== 8'h02) begin
         errors++;
         $display("FAIL x0_second got ready=%b tag=%h want ready=1 tag=02", issue_ready_o, issue_tag_o);
      end
      step();
      idle();
      checks++;
      if (inflight_o !== 4'd2) begin
         errors++; $display("FAIL x0_inflight got %0d want 2", inflight_o);
      end
   endtask

   task automatic test_recycle();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive_issue(5'(i + 1), 5'd0, 5'd0);
         step();
      end
      idle();
      drive_retire(8'h04);
      step();
      drive_retire(8'h10);
      step();
      idle();
      checks++;
      if (inflight_o !== 4'd6) begin
         errors++; $display("FAIL recycle_inflight got %0d want 6", inflight_o);
      end
      drive_issue(5'd0, 5'd0, 5'd0);
      checks++;
      if (issue_ready_o !== 1'b1 || issue_tag_o !== 8'h04) begin
         errors++;
         $display("FAIL recycle_first got ready=%b tag=%h want ready=1 tag=04", issue_ready_o, issue_tag_o);
      end
      step();
      checks++;
      if (issue_ready_o !== 1'b1 || issue_tag_o !== 8'h10) begin
         errors++;
         $display("FAIL recycle_second got ready=%b tag=%h want ready=1 tag=10", issue_ready_o, issue_tag_o);
      end
      step();
      idle();
      checks++;
      if (issue_ready_o !== 1'b0 || inflight_o !== 4'd8) begin
         errors++;
         $display("FAIL recycle_full got ready=%b inflight=%0d want ready=0 inflight=8", issue_ready_o, inflight_o);
      end
   endtask

   task automatic test_illegal();
      logic [7:0] bad [3];
      bad[0] = 8'h03;
      bad[1] = 8'h00;
      bad[2] = 8'h08;
      apply_reset();
      drive_issue(5'd1, 5'd0, 5'd0);
      step();
      drive_issue(5'd2, 5'd0, 5'd0);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         drive_retire(bad[i]);
         step();
         checks++;
         if (err_o !== 1'b1 || inflight_o !== 4'd2) begin
            errors++;
            $display("FAIL illegal%0d_pulse got err=%b inflight=%0d want err=1 inflight=2", i, err_o, inflight_o);
         end
         idle();
         step();
         checks++;
         if (err_o !== 1'b0) begin
            errors++; $display("FAIL illegal%0d_once got err=%b want 0", i, err_o);
         end
      end
      drive_retire(8'h02);
      step();
      idle();
      checks++;
      if (err_o !== 1'b0 || inflight_o !== 4'd1) begin
         errors++;
         $display("FAIL legal_retire got err=%b inflight=%0d want err=0 inflight=1", err_o, inflight_o);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive_issue(5'(i + 1), 5'd0, 5'd0);
         step();
      end
      idle();
      checks++;
      if (inflight_o !== 4'd3) begin
         errors++; $display("FAIL simul_pre got %0d want 3", inflight_o);
      end
      drive_issue(5'd4, 5'd0, 5'd0);
      drive_retire(8'h01);
      checks++;
      if (issue_ready_o !== 1'b1 || issue_tag_o !== 8'h08) begin
         errors++;
         $display("FAIL simul_grant got ready=%b tag=%h want ready=1 tag=08", issue_ready_o, issue_tag_o);
      end
      step();
      idle();
      checks++;
      if (inflight_o !== 4'd3 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL simul_inflight got %0d err=%b want 3 err=0", inflight_o, err_o);
      end
      checks++;
      if (issue_tag_o !== 8'h10) begin
         errors++; $display("FAIL simul_next_head got %h want 10", issue_tag_o);
      end
      for (int i = 0; i < 2; i++) begin
         drive_issue(5'(i + 5), 5'd0, 5'd0);
         step();
      end
      idle();
      checks++;
      if (inflight_o !== 4'd5) begin
         errors++; $display("FAIL midrst_pre got %0d want 5", inflight_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (inflight_o !== 4'd0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async got inflight=%0d err=%b want 0 0", inflight_o, err_o);
      end
      step();
      rst_ni = 1'b1;
      #1;
      checks++;
      if (issue_ready_o !== 1'b1 || issue_tag_o !== 8'h01 || inflight_o !== 4'd0) begin
         errors++;
         $display("FAIL midrst_after got ready=%b tag=%h inflight=%0d want 1 01 0",
                  issue_ready_o, issue_tag_o, inflight_o);
      end
   endtask

   initial begin
      rst_ni = 1'b1;
      idle();
      test_reset();
      test_fill_order();
      test_raw_hazard();
      test_x0();
      test_recycle();
      test_illegal();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
